pulse_count_sequencer: RTL and testbench

Measurement controller for the VMOD pulse-count datapath. It sequences gated count windows, selects the long or short window (manual or auto-range), and counts synchronised VMOD rising edges. Each result is handed to the readout side over a VALID/ACK handshake. It replaces free-running timer gating with start/stop control, saturation detection and a defined latency.

---
 rtl/pulse_count_sequencer_if.sv | 26 ++
 rtl/pulse_count_sequencer.sv | 152 +++++++++++++++
 tb/tb_pulse_count_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_count_sequencer_if.sv
// Control/result bundle between the pulse-count sequencer and its controller.
// The master side drives the measurement controls and the result acknowledge.
interface pulse_count_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic             CONT;
    logic             MODE;
    logic             AUTO;
    logic             ACK;
    logic [CNT_W-1:0] Q;
    logic             OVF;
    logic             MODE_USED;
    logic             VALID;
    logic             BUSY;

    modport master (
        output START, CONT, MODE, AUTO, ACK,
        input  Q, OVF, MODE_USED, VALID, BUSY
    );

    modport slave (
        input  START, CONT, MODE, AUTO, ACK,
        output Q, OVF, MODE_USED, VALID, BUSY
    );
endinterface

// File: rtl/pulse_count_sequencer.sv
// Gated VMOD edge counter with long/short/auto-range windows and a VALID/ACK
// result handshake. One measurement per START, or continuous with CONT.
module pulse_count_sequencer #(
    parameter int CNT_W       = 16,
    parameter int LONG_WIN    = 65535,
    parameter int SHORT_WIN   = 32768,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   VMOD,
    pulse_count_sequencer_if.slave bus
);

    localparam int MAX_WIN = (LONG_WIN > SHORT_WIN) ? LONG_WIN : SHORT_WIN;
    localparam int TMR_W   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

    localparam logic [TMR_W-1:0] LONG_LAST  = TMR_W'(LONG_WIN - 1);
    localparam logic [TMR_W-1:0] SHORT_LAST = TMR_W'(SHORT_WIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_HOLD
    } state_t;

    // VMOD synchroniser plus one history flop for rising-edge detection
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], VMOD};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             sel_reg;       // window of the running gate (1 = short)
    logic             base_sel_reg;  // window chosen at START, reused on re-arm
    logic             auto_reg;
    logic [CNT_W-1:0] q_reg;
    logic             ovf_out_reg;
    logic             mode_used_reg;
    logic             valid_reg;
    logic             busy_reg;

    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             last_tick;

    // Count including the edge seen this cycle, so the final gate cycle counts too
    always_comb begin
        cnt_next  = cnt_reg;
        ovf_next  = ovf_reg;
        if (rise) begin
            if (&cnt_reg) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        last_tick = sel_reg ? (timer_reg == SHORT_LAST) : (timer_reg == LONG_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            sel_reg       <= 1'b0;
            base_sel_reg  <= 1'b0;
            auto_reg      <= 1'b0;
            q_reg         <= '0;
            ovf_out_reg   <= 1'b0;
            mode_used_reg <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.START) begin
                        state_reg    <= ST_ARM;
                        busy_reg     <= 1'b1;
                        auto_reg     <= bus.AUTO;
                        sel_reg      <= bus.AUTO ? 1'b0 : bus.MODE;
                        base_sel_reg <= bus.AUTO ? 1'b0 : bus.MODE;
                    end
                end
                ST_ARM: begin
                    timer_reg <= '0;
                    cnt_reg   <= '0;
                    ovf_reg   <= 1'b0;
                    state_reg <= ST_GATE;
                end
                ST_GATE: begin
                    cnt_reg   <= cnt_next;
                    ovf_reg   <= ovf_next;
                    timer_reg <= timer_reg + TMR_W'(1);
                    if (last_tick) begin
                        // Auto-range: an overflowing long window is silently retried short
                        if (auto_reg && !sel_reg && ovf_next) begin
                            sel_reg   <= 1'b1;
                            state_reg <= ST_ARM;
                        end else begin
                            q_reg         <= cnt_next;
                            ovf_out_reg   <= ovf_next;
                            mode_used_reg <= sel_reg;
                            valid_reg     <= 1'b1;
                            state_reg     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.ACK) begin
                        valid_reg <= 1'b0;
                        if (bus.CONT) begin
                            sel_reg   <= base_sel_reg;
                            state_reg <= ST_ARM;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q         = q_reg;
    assign bus.OVF       = ovf_out_reg;
    assign bus.MODE_USED = mode_used_reg;
    assign bus.VALID     = valid_reg;
    assign bus.BUSY      = busy_reg;

endmodule

// File: tb/tb_pulse_count_sequencer.sv
// Bench for pulse_count_sequencer: directed table, hand sequences for
// handshake/continuous/reset, and randomized measurements against a window model.
module tb_pulse_count_sequencer;

    localparam int CW   = 3;
    localparam int LW   = 16;
    localparam int SW   = 8;
    localparam int MAXQ = 7;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic vmod = 1'b0;

    pulse_count_sequencer_if #(.CNT_W(CW)) bus ();

    pulse_count_sequencer #(
        .CNT_W      (CW),
        .LONG_WIN   (LW),
        .SHORT_WIN  (SW),
        .SYNC_STAGES(2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .VMOD(vmod),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;   // index of the most recent posedge
    int pat    = 3;    // 0 pulse/4, 1 toggle, 2 high, 3 low, 4 random
    int dens   = 50;
    bit vhist[0:8191]; // VMOD value sampled at each posedge

    typedef struct {
        bit mode;
        bit au;
        int pat;
        int q;
        bit ovf;
        bit mu;
        int lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; drive VMOD for the next edge and record it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (pat)
            0:       vmod = ((cyc + 1) % 4 == 0);
            1:       vmod = ((cyc + 1) % 2 == 0);
            2:       vmod = 1'b1;
            4:       vmod = (int'($urandom_range(0, 99)) < dens);
            default: vmod = 1'b0;
        endcase
        vhist[cyc + 1] = vmod;
    endtask

    // Rising edges of the sampled VMOD among samples lo..hi
    function automatic int cnt_rises(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (vhist[i] && !vhist[i - 1]) n++;
        return n;
    endfunction

    // Expected result of a measurement whose START/ACK was sampled at edge s.
    // The gate sees VMOD with a two-edge synchroniser delay, so the window's
    // samples are s..s+W-1; VALID appears after edge s+W+1.
    task automatic model(input bit a, input bit m, input int s,
                         output int q, output bit o, output bit mu, output int lat);
        int c;
        int w;
        if (a) begin
            c = cnt_rises(s, s + LW - 1);
            if (c > MAXQ) begin
                c   = cnt_rises(s + LW + 1, s + LW + SW);
                mu  = 1'b1;
                lat = LW + SW + 2;
            end else begin
                mu  = 1'b0;
                lat = LW + 1;
            end
        end else begin
            w   = m ? SW : LW;
            c   = cnt_rises(s, s + w - 1);
            mu  = m;
            lat = w + 1;
        end
        q = (c > MAXQ) ? MAXQ : c;
        o = (c > MAXQ);
    endtask

    task automatic start_meas(input bit m, input bit a, output int s);
        bus.MODE  = m;
        bus.AUTO  = a;
        bus.START = 1'b1;
        step();
        s         = cyc;
        bus.START = 1'b0;
        chk("busy_after_start", 32'(bus.BUSY), 1);
    endtask

    // Wait (bounded) for VALID; optionally inject ignored START/ACK and MODE/AUTO changes
    task automatic wait_valid(input int base, input bit noise, output int lat);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (bus.VALID) begin
                got = 1'b1;
            end else if (noise) begin
                bus.START = 1'($urandom_range(0, 1));
                bus.ACK   = 1'($urandom_range(0, 1));
                bus.MODE  = 1'($urandom_range(0, 1));
                bus.AUTO  = 1'($urandom_range(0, 1));
            end
        end
        bus.START = 1'b0;
        bus.ACK   = 1'b0;
        lat = cyc - base;
        if (!got) begin
            chk("valid_timeout", 0, 1);
            lat = -1;
        end
    endtask

    task automatic check_result(input string tag, input int q, input bit o, input bit mu,
                                input int lat_exp, input int lat);
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_q"}, 32'(bus.Q), q);
        chk({tag, "_ovf"}, 32'(bus.OVF), 32'(o));
        chk({tag, "_mode_used"}, 32'(bus.MODE_USED), 32'(mu));
        chk({tag, "_busy"}, 32'(bus.BUSY), 1);
    endtask

    // Hold the result for some cycles (with ignored START pulses), then ACK
    task automatic release_result(input bit cont, input int hold,
                                  input int q, input bit o, input bit mu);
        bus.CONT = cont;
        for (int k = 0; k < hold; k++) begin
            bus.START = (k % 2 == 0);
            step();
            chk("hold_stable", 32'({bus.VALID, bus.OVF, bus.MODE_USED, bus.Q}),
                32'({1'b1, o, mu, 3'(q)}));
        end
        bus.START = 1'b0;
        bus.ACK   = 1'b1;
        step();
        bus.ACK   = 1'b0;
        chk("valid_drop", 32'(bus.VALID), 0);
        chk("busy_after_ack", 32'(bus.BUSY), 32'(cont));
        chk("result_kept", 32'({bus.OVF, bus.MODE_USED, bus.Q}), 32'({o, mu, 3'(q)}));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q"}, 32'(bus.Q), 0);
        chk({tag, "_ovf"}, 32'(bus.OVF), 0);
        chk({tag, "_mode_used"}, 32'(bus.MODE_USED), 0);
        chk({tag, "_valid"}, 32'(bus.VALID), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int a;
        int lat;
        int eq;
        int elat;
        bit eo;
        bit emu;
        bit m;
        bit au;

        bus.START = 1'b0;
        bus.CONT  = 1'b0;
        bus.MODE  = 1'b0;
        bus.AUTO  = 1'b0;
        bus.ACK   = 1'b0;

        //           mode au  pat  q  ovf mu  lat
        vecs[0] = '{1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 17};  // basic count
        vecs[1] = '{1'b0, 1'b0, 1, 7, 1'b1, 1'b0, 17};  // long saturates
        vecs[2] = '{1'b1, 1'b0, 1, 4, 1'b0, 1'b1, 9};   // short window
        vecs[3] = '{1'b0, 1'b1, 1, 4, 1'b0, 1'b1, 26};  // auto retry short
        vecs[4] = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 17};  // level never counts
        vecs[5] = '{1'b1, 1'b1, 0, 4, 1'b0, 1'b0, 17};  // auto ignores MODE

        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) step();

        bus.ACK = 1'b1;
        step();
        bus.ACK = 1'b0;
        chk("idle_ack_valid", 32'(bus.VALID), 0);
        chk("idle_ack_busy", 32'(bus.BUSY), 0);

        for (int i = 0; i < 6; i++) begin
            pat = vecs[i].pat;
            repeat (4) step();
            start_meas(vecs[i].mode, vecs[i].au, s);
            wait_valid(s, 1'b0, lat);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].ovf, vecs[i].mu,
                         vecs[i].lat, lat);
            $display("vec %0d mode=%0d auto=%0d q=%0d ovf=%0d mode_used=%0d latency=%0d",
                     i, vecs[i].mode, vecs[i].au, bus.Q, bus.OVF, bus.MODE_USED, lat);
            release_result(1'b0, 2, vecs[i].q, vecs[i].ovf, vecs[i].mu);
            pat = 3;
        end

        // Continuous: long hold, re-arm on ACK with CONT=1, then stop
        pat = 0;
        repeat (4) step();
        start_meas(1'b1, 1'b0, s);
        wait_valid(s, 1'b0, lat);
        model(1'b0, 1'b1, s, eq, eo, emu, elat);
        check_result("cont1", eq, eo, emu, elat, lat);
        $display("cont first q=%0d latency=%0d", bus.Q, lat);
        release_result(1'b1, 10, eq, eo, emu);
        a = cyc;
        wait_valid(a, 1'b0, lat);
        model(1'b0, 1'b1, a, eq, eo, emu, elat);
        check_result("cont2", eq, eo, emu, elat, lat);
        $display("cont rearm q=%0d latency_from_ack=%0d", bus.Q, lat);
        release_result(1'b0, 1, eq, eo, emu);

        // Reset in the middle of a long gate discards the window
        repeat (4) step();
        start_meas(1'b0, 1'b0, s);
        while (cyc < s + 7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("mid_reset");
        $display("mid-gate reset at cycle %0d", cyc);
        pat = 3;
        repeat (4) step();
        pat = 0;
        start_meas(1'b0, 1'b0, s);
        wait_valid(s, 1'b0, lat);
        check_result("post_reset", vecs[0].q, vecs[0].ovf, vecs[0].mu, vecs[0].lat, lat);
        $display("post-reset q=%0d latency=%0d", bus.Q, lat);
        release_result(1'b0, 0, vecs[0].q, vecs[0].ovf, vecs[0].mu);

        // Randomized measurements against the window model
        for (int i = 0; i < 24; i++) begin
            m    = 1'($urandom_range(0, 1));
            au   = 1'($urandom_range(0, 1));
            dens = 15 + 30 * int'($urandom_range(0, 2));
            pat  = 4;
            repeat (2) step();
            start_meas(m, au, s);
            wait_valid(s, 1'b1, lat);
            model(au, m, s, eq, eo, emu, elat);
            check_result($sformatf("rand%0d", i), eq, eo, emu, elat, lat);
            $display("rand %0d mode=%0d auto=%0d dens=%0d q=%0d exp_q=%0d ovf=%0d mode_used=%0d latency=%0d",
                     i, m, au, dens, bus.Q, eq, bus.OVF, bus.MODE_USED, lat);
            release_result(1'b0, int'($urandom_range(0, 3)), eq, eo, emu);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
